// File: rtl/div_ctrl_if.sv
// div_ctrl_if: EX-stage divide handshake plus the divider start/result bus
interface div_ctrl_if;
  logic        op_valid;
  logic        op_signed;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        flush;
  logic        wb_stall;
  logic        stall_ex;
  logic        hilo_we;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dbz;
  logic        err;
  logic        div_start;
  logic        div_annul;
  logic        div_signed;
  logic [31:0] div_opa;
  logic [31:0] div_opb;
  logic [63:0] div_result;
  logic        div_ready;
  modport master (
    output op_valid, op_signed, opa, opb, flush, wb_stall, div_result, div_ready,
    input  stall_ex, hilo_we, hi, lo, dbz, err, div_start, div_annul, div_signed, div_opa, div_opb
  );
  modport slave (
    input  op_valid, op_signed, opa, opb, flush, wb_stall, div_result, div_ready,
    output stall_ex, hilo_we, hi, lo, dbz, err, div_start, div_annul, div_signed, div_opa, div_opb
  );
endinterface

// File: rtl/div_ctrl.sv
// div_ctrl: execute-stage sequencer for the shared iterative divider
module div_ctrl #(
  parameter int CANCEL_CYCLES = 3,
  parameter int TIMEOUT = 48
) (
  input logic clk,
  input logic rst,
  div_ctrl_if.slave bus
);
  localparam int CW = $clog2((TIMEOUT > CANCEL_CYCLES ? TIMEOUT : CANCEL_CYCLES) + 1);
  typedef enum logic [2:0] {IDLE, BUSY, DONE, DRAIN, CANCEL} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0] opa, opb, hi, lo;
  logic sgn, dbz_flag, err;
  logic accept, timeout, annul_done, write;
  // a stale ready from the previous op must clear before new work is taken
  assign accept = state == IDLE && bus.op_valid && !bus.flush && !bus.div_ready;
  assign timeout = state == BUSY && !bus.flush && !bus.div_ready && cnt == CW'(TIMEOUT - 1);
  assign annul_done = cnt >= CW'(CANCEL_CYCLES - 1);
  assign write = state == DONE && !bus.flush && !bus.wb_stall;
  always_ff @(posedge clk) state <= !rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? BUSY : IDLE;
      BUSY:    state_nx = bus.flush || timeout ? CANCEL : bus.div_ready ? DONE : BUSY;
      DONE:    state_nx = bus.flush || !bus.wb_stall ? DRAIN : DONE;
      DRAIN:   state_nx = bus.div_ready ? DRAIN : IDLE;
      CANCEL:  state_nx = annul_done && !bus.div_ready ? IDLE : CANCEL;
      default: state_nx = IDLE;
    endcase
  end
  // cnt times BUSY for the timeout and CANCEL for the annul window, saturating in CANCEL
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      opa <= '0;
      opb <= '0;
      sgn <= 1'b0;
      dbz_flag <= 1'b0;
      hi <= '0;
      lo <= '0;
      err <= 1'b0;
    end else begin
      if (accept) begin
        opa <= bus.opa;
        opb <= bus.opb;
        sgn <= bus.op_signed;
        dbz_flag <= bus.opb == '0;
      end
      if (state == BUSY && bus.div_ready && !bus.flush) {hi, lo} <= bus.div_result;
      if (timeout) err <= 1'b1;
      cnt <= state_nx != state ? '0
           : state == BUSY || (state == CANCEL && cnt < CW'(CANCEL_CYCLES)) ? cnt + 1'b1 : cnt;
    end
  end
  always_comb begin
    bus.div_start = state == BUSY;
    bus.div_annul = state == CANCEL && cnt < CW'(CANCEL_CYCLES);
    bus.hilo_we = write;
    bus.dbz = write && dbz_flag;
    bus.stall_ex = state == BUSY || (state == DONE && bus.wb_stall && !bus.flush)
                || ((state == IDLE || state == DRAIN) && bus.op_valid);
    bus.div_signed = sgn;
    bus.div_opa = opa;
    bus.div_opb = opb;
    bus.hi = hi;
    bus.lo = lo;
    bus.err = err;
  end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed and randomized checks of div_ctrl against a behavioural model
module tb_div_ctrl;
  localparam int P_IDLE = 0, P_BUSY = 1, P_DONE = 2, P_DRAIN = 3, P_CANCEL = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  div_ctrl_if bus();
  div_ctrl #(.CANCEL_CYCLES(3), .TIMEOUT(48)) dut (.clk(clk), .rst(rst), .bus(bus));
  int vectors = 0, miscompares = 0;
  logic s_rst, s_valid, s_signed, s_flush, s_wbst;
  logic [31:0] s_a, s_b;
  int dv_cnt, dv_hold, dv_lat, rel_lag;
  logic dv_ready, stuck;
  logic [63:0] dv_res;
  int ph, cn;
  logic [31:0] m_hi, m_lo, m_opa, m_opb;
  logic m_sgn, m_dbz, m_err;
  logic [64:0] exp_q[$];
  int w_cnt;
  logic [31:0] w_hi, w_lo;
  logic w_dbz, o_start, o_annul, o_err;

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sg);
    longint sa, sd, q, r;
    if (b == 0) return '0;
    sa = sg ? longint'($signed(a)) : longint'({32'd0, a});
    sd = sg ? longint'($signed(b)) : longint'({32'd0, b});
    q = sa / sd;
    r = sa % sd;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(1, 300));
      4: return -32'($urandom_range(1, 300));
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // one clock: divider model + stimulus at negedge, compare, then advance the model
  task automatic step();
    logic e_start, e_annul, e_stall, e_we;
    @(negedge clk);
    if (!bus.div_start) begin
      if (dv_ready && dv_hold < rel_lag) dv_hold++;
      else begin dv_ready = 1'b0; dv_hold = 0; dv_cnt = 0; end
    end else if (!dv_ready && !stuck) begin
      dv_cnt++;
      if (dv_cnt >= (bus.div_opb == 0 ? 3 : dv_lat)) begin
        dv_ready = 1'b1;
        dv_res = ref_div(bus.div_opa, bus.div_opb, bus.div_signed);
      end
    end
    rst = s_rst;
    bus.op_valid = s_valid;
    bus.op_signed = s_signed;
    bus.opa = s_a;
    bus.opb = s_b;
    bus.flush = s_flush;
    bus.wb_stall = s_wbst;
    bus.div_ready = dv_ready;
    bus.div_result = dv_res;
    #1;
    e_start = ph == P_BUSY;
    e_annul = ph == P_CANCEL && cn < 3;
    e_we = ph == P_DONE && !s_flush && !s_wbst;
    e_stall = (ph == P_IDLE || ph == P_DRAIN) ? s_valid : ph == P_BUSY ? 1'b1
            : ph == P_DONE ? (!s_flush && s_wbst) : 1'b0;
    chk("div_start", 65'(bus.div_start), 65'(e_start));
    chk("div_annul", 65'(bus.div_annul), 65'(e_annul));
    chk("stall_ex", 65'(bus.stall_ex), 65'(e_stall));
    chk("hilo_we", 65'(bus.hilo_we), 65'(e_we));
    chk("dbz", 65'(bus.dbz), 65'(e_we && m_dbz));
    chk("err", 65'(bus.err), 65'(m_err));
    chk("hi", 65'(bus.hi), 65'(m_hi));
    chk("lo", 65'(bus.lo), 65'(m_lo));
    chk("div_opa", 65'(bus.div_opa), 65'(m_opa));
    chk("div_opb", 65'(bus.div_opb), 65'(m_opb));
    chk("div_signed", 65'(bus.div_signed), 65'(m_sgn));
    if (e_we && exp_q.size() != 0) chk("wb_result", {bus.dbz, bus.hi, bus.lo}, exp_q[0]);
    o_start = bus.div_start;
    o_annul = bus.div_annul;
    o_err = bus.err;
    if (bus.hilo_we) begin w_cnt++; w_hi = bus.hi; w_lo = bus.lo; w_dbz = bus.dbz; end
    if (!s_rst) begin
      ph = P_IDLE; cn = 0;
      m_hi = '0; m_lo = '0; m_opa = '0; m_opb = '0; m_sgn = 1'b0; m_dbz = 1'b0; m_err = 1'b0;
      exp_q.delete();
      dv_ready = 1'b0; dv_hold = 0; dv_cnt = 0;
    end else if (ph == P_IDLE) begin
      if (s_valid && !s_flush && !dv_ready) begin
        m_opa = s_a; m_opb = s_b; m_sgn = s_signed; m_dbz = s_b == 0;
        exp_q.push_back({s_b == 0, ref_div(s_a, s_b, s_signed)});
        ph = P_BUSY; cn = 0;
      end
    end else if (ph == P_BUSY) begin
      if (s_flush) begin ph = P_CANCEL; cn = 0; exp_q.delete(); end
      else if (dv_ready) begin m_hi = dv_res[63:32]; m_lo = dv_res[31:0]; ph = P_DONE; end
      else if (cn == 47) begin m_err = 1'b1; ph = P_CANCEL; cn = 0; exp_q.delete(); end
      else cn++;
    end else if (ph == P_DONE) begin
      if (s_flush) begin ph = P_DRAIN; exp_q.delete(); end
      else if (!s_wbst) begin ph = P_DRAIN; if (exp_q.size() != 0) void'(exp_q.pop_front()); end
    end else if (ph == P_DRAIN) begin
      if (!dv_ready) ph = P_IDLE;
    end else begin
      if (cn >= 2 && !dv_ready) ph = P_IDLE;
      else if (cn < 3) cn++;
    end
    @(posedge clk);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sg);
    s_valid = 1'b1; s_a = a; s_b = b; s_signed = sg;
    step();
    s_valid = 1'b0;
  endtask

  task automatic wait_write(input int budget, output int cyc);
    int w0;
    w0 = w_cnt;
    cyc = 0;
    while (w_cnt == w0 && cyc < budget) begin step(); cyc++; end
    if (w_cnt == w0) begin
      miscompares++;
      $display("FAIL write_timeout: no hilo_we within %0d cycles", budget);
    end
  endtask

  initial begin
    int n, cyc, w0;
    s_rst = 1'b0; s_valid = 1'b0; s_signed = 1'b0; s_flush = 1'b0; s_wbst = 1'b0; s_a = '0; s_b = '0;
    dv_cnt = 0; dv_hold = 0; dv_lat = 34; rel_lag = 0; dv_ready = 1'b0; stuck = 1'b0; dv_res = '0;
    ph = P_IDLE; cn = 0; m_hi = '0; m_lo = '0; m_opa = '0; m_opb = '0; m_sgn = 1'b0; m_dbz = 1'b0; m_err = 1'b0;
    w_cnt = 0; w_hi = '0; w_lo = '0; w_dbz = 1'b0; o_start = 1'b0; o_annul = 1'b0; o_err = 1'b0;
    repeat (3) step();
    #2;
    chk("rst_ctrl", 65'({bus.stall_ex, bus.hilo_we, bus.dbz, bus.err, bus.div_start, bus.div_annul, bus.div_signed}), 65'd0);
    chk("rst_hilo", 65'({bus.hi, bus.lo}), 65'd0);
    chk("rst_ops", 65'({bus.div_opa, bus.div_opb}), 65'd0);
    s_rst = 1'b1;
    step();
    issue(32'd100, 32'd7, 1'b0);
    wait_write(60, cyc);
    chk("divu_latency", 65'(cyc), 65'd35);
    chk("divu_hi", 65'(w_hi), 65'd2);
    chk("divu_lo", 65'(w_lo), 65'd14);
    chk("divu_dbz", 65'(w_dbz), 65'd0);
    repeat (3) step();
    issue(32'hFFFF_FF9C, 32'd7, 1'b1);
    wait_write(60, cyc);
    chk("div_neg_hi", 65'(w_hi), 65'h0_FFFF_FFFE);
    chk("div_neg_lo", 65'(w_lo), 65'h0_FFFF_FFF2);
    repeat (3) step();
    issue(32'd5, 32'd0, 1'b1);
    wait_write(10, cyc);
    chk("dbz_latency", 65'(cyc), 65'd4);
    chk("dbz_hilo", 65'({w_hi, w_lo}), 65'd0);
    chk("dbz_flag", 65'(w_dbz), 65'd1);
    repeat (3) step();
    issue(32'd50, 32'd7, 1'b0);
    repeat (9) step();
    w0 = w_cnt;
    s_flush = 1'b1;
    step();
    s_flush = 1'b0;
    n = 0;
    repeat (8) begin step(); if (o_annul) n++; end
    chk("annul_cycles", 65'(n), 65'd3);
    chk("flush_no_write", 65'(w_cnt), 65'(w0));
    issue(32'd9, 32'd3, 1'b0);
    wait_write(60, cyc);
    chk("after_flush_hi", 65'(w_hi), 65'd0);
    chk("after_flush_lo", 65'(w_lo), 65'd3);
    repeat (3) step();
    s_wbst = 1'b1;
    w0 = w_cnt;
    issue(32'd20, 32'd6, 1'b0);
    n = 0;
    while (!dv_ready && n < 60) begin step(); n++; end
    repeat (5) step();
    chk("wbst_held", 65'(w_cnt), 65'(w0));
    s_wbst = 1'b0;
    wait_write(3, cyc);
    chk("wbst_release", 65'(cyc), 65'd1);
    repeat (4) step();
    chk("wbst_single", 65'(w_cnt), 65'(w0 + 1));
    chk("wbst_hilo", 65'({w_hi, w_lo}), 65'({32'd2, 32'd3}));
    rel_lag = 3;
    issue(32'd77, 32'd5, 1'b0);
    wait_write(60, cyc);
    chk("b2b_a", 65'({w_hi, w_lo}), 65'({32'd2, 32'd15}));
    s_valid = 1'b1; s_a = 32'd40; s_b = 32'd8; s_signed = 1'b0;
    n = 0;
    do begin step(); n++; end while (!o_start && n < 10);
    chk("b2b_accept", 65'(n), 65'd5);
    s_valid = 1'b0;
    wait_write(60, cyc);
    chk("b2b_b", 65'({w_hi, w_lo}), 65'({32'd0, 32'd5}));
    rel_lag = 0;
    repeat (6) step();
    stuck = 1'b1;
    issue(32'd1, 32'd1, 1'b0);
    repeat (48) step();
    chk("err_before", 65'(o_err), 65'd0);
    step();
    chk("err_after", 65'(o_err), 65'd1);
    chk("timeout_annul", 65'(o_annul), 65'd1);
    stuck = 1'b0;
    repeat (5) step();
    for (int i = 0; i < 4000; i++) begin
      s_rst = $urandom_range(0, 499) != 0;
      s_flush = $urandom_range(0, 59) == 0;
      s_wbst = $urandom_range(0, 2) == 0;
      if (!s_valid || $urandom_range(0, 3) == 0) begin
        s_valid = $urandom_range(0, 2) == 0;
        s_signed = 1'($urandom_range(0, 1));
        s_a = pick();
        s_b = pick();
      end
      if (!o_start) begin
        dv_lat = $urandom_range(1, 40);
        rel_lag = $urandom_range(0, 3);
        stuck = $urandom_range(0, 39) == 0;
      end
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
